// File: rtl/montgomery_domain_entry.sv
// montgomery_domain_entry: converts an operand a (normal domain) into the
// Montgomery domain, out = (a * 2^K) mod Q, using K iterations of modular
// doubling. One operand is in flight at a time.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand valid
//   in_ready   block can accept an operand (IDLE only)
//   in_data    operand a, legal range 0..Q-1
//   out_valid  result valid (DONE)
//   out_ready  downstream accepts result
//   out_data   (a * 2^K) mod Q, zero-extended
//   out_err    qualified by out_valid; operand was >= Q
//   busy       high in BUSY or DONE
`timescale 1ns/1ps

module montgomery_domain_entry #(
  parameter int unsigned Q          = 8380417,
  parameter int unsigned K          = 23,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err,
  output logic                  busy
);

  // Accumulator holds values 0..Q-1; doubled value needs one extra bit.
  localparam int unsigned AW  = $clog2(Q);
  localparam int unsigned DW2 = AW + 1;
  localparam int unsigned CW  = $clog2(K + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           acc_q, acc_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_err_q, out_err_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;

  logic [DW2-1:0]          dbl;
  logic [DW2-1:0]          dbl_red;
  logic [AW-1:0]           acc_next;
  logic                    in_oor;

  // Modular doubling; a single conditional subtract suffices since acc < Q.
  always_comb begin
    dbl      = {acc_q, 1'b0};
    dbl_red  = (dbl >= DW2'(Q)) ? (dbl - DW2'(Q)) : dbl;
    acc_next = AW'(dbl_red);
    in_oor   = (in_data >= DATA_WIDTH'(Q));
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          if (in_oor) begin
            out_data_d = '0;
            out_err_d  = 1'b1;
            state_d    = S_DONE;
          end else begin
            acc_d   = AW'(in_data);
            cnt_d   = '0;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        acc_d = acc_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(K - 1)) begin
          out_data_d = DATA_WIDTH'(acc_next);
          out_err_d  = 1'b0;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake flags are registered decodes of the next state.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign busy      = busy_q;

endmodule
